// File: rtl/axis_pattern_pkg.sv
// Shared types and constants for the AXI4-Stream pattern generator.
// Holds the mode/state encodings and the Fibonacci LFSR tap masks.
package axis_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_CNT    = 2'd0,
        MODE_CONST  = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_TOGGLE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Maximal-length taps: x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            32:      return 32'h8020_0003;
            default: return 32'h0000_00B8;
        endcase
    endfunction

endpackage

// File: rtl/axis_pattern_lfsr.sv
// Fibonacci LFSR used by the pattern generator; shifts left, feedback into bit 0.
// next_value exposes the state the register will hold after this edge.
module axis_pattern_lfsr
    import axis_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] value,
    output logic [DATA_WIDTH-1:0] next_value
);

    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] r_state;
    logic [DATA_WIDTH-1:0] w_next;

    // Next state: a zero seed would lock the register up, so it becomes 1.
    always_comb begin
        w_next = r_state;
        if (load) begin
            w_next = (seed == '0) ? DATA_WIDTH'(1) : seed;
        end else if (advance) begin
            w_next = {r_state[DATA_WIDTH-2:0], ^(r_state & TAPS)};
        end else begin
            w_next = r_state;
        end
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= DATA_WIDTH'(1);
        end else begin
            r_state <= w_next;
        end
    end

    assign value      = r_state;
    assign next_value = w_next;

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream pattern source: counter / constant / LFSR / toggle data with optional
// tlast framing, backpressure handling and a completed-packet status counter.
module axis_pattern_gen
    import axis_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int STS_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  cfg_enable,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_init,
    input  logic [DATA_WIDTH-1:0] cfg_step,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [STS_WIDTH-1:0]  sts_pkt_cnt,
    output logic                  sts_busy
);

    state_e                r_state;
    mode_e                 r_mode;
    logic [DATA_WIDTH-1:0] r_init;
    logic [DATA_WIDTH-1:0] r_step;
    logic [LEN_WIDTH-1:0]  r_pkt_len;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [STS_WIDTH-1:0]  r_pkt_cnt;
    logic                  r_busy;

    state_e                w_state_next;
    logic                  w_beat_done;
    logic                  w_framed;
    logic                  w_latch_cfg;
    logic                  w_start;
    logic                  w_advance;
    logic                  w_restart;
    logic                  w_stop;
    logic                  w_pkt_done;
    logic                  w_continue;
    logic                  w_carry;
    logic                  w_lfsr_load;
    logic                  w_lfsr_adv;
    logic [DATA_WIDTH-1:0] w_lfsr_value;
    logic [DATA_WIDTH-1:0] w_lfsr_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_last_next;
    logic                  w_valid_next;
    logic [LEN_WIDTH-1:0]  w_cnt_next;

    assign w_beat_done = r_tvalid & m_axis_tready;
    assign w_framed    = (r_pkt_len != '0);
    // Counter and LFSR keep running across a packet boundary unless the mode changes.
    assign w_continue  = (mode_e'(cfg_mode) == r_mode) &&
                         ((r_mode == MODE_CNT) || (r_mode == MODE_LFSR));
    assign w_carry     = w_restart & w_continue;
    assign w_lfsr_load = w_latch_cfg & ~w_carry;
    assign w_lfsr_adv  = (w_advance | w_carry) & (r_mode == MODE_LFSR);

    axis_pattern_lfsr #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lfsr (
        .aclk       (aclk),
        .reset      (reset),
        .load       (w_lfsr_load),
        .seed       (cfg_init),
        .advance    (w_lfsr_adv),
        .value      (w_lfsr_value),
        .next_value (w_lfsr_next)
    );

    // Next-state logic and per-cycle action strobes.
    always_comb begin
        w_state_next = r_state;
        w_latch_cfg  = 1'b0;
        w_start      = 1'b0;
        w_advance    = 1'b0;
        w_restart    = 1'b0;
        w_stop       = 1'b0;
        w_pkt_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_enable) begin
                    w_latch_cfg  = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (!r_tvalid) begin
                    w_start = 1'b1;
                end else if (w_beat_done) begin
                    if (r_tlast) begin
                        w_pkt_done = 1'b1;
                        if (cfg_enable && (r_state == ST_RUN)) begin
                            w_latch_cfg = 1'b1;
                            w_restart   = 1'b1;
                        end else begin
                            w_stop       = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end else if (!cfg_enable && !w_framed) begin
                        w_stop       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_advance = 1'b1;
                        if (!cfg_enable) begin
                            w_state_next = ST_DRAIN;
                        end else begin
                            w_state_next = r_state;
                        end
                    end
                end else if (!cfg_enable && w_framed) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = r_state;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Next beat contents.
    always_comb begin
        w_data_next  = r_tdata;
        w_last_next  = r_tlast;
        w_cnt_next   = r_beat_cnt;
        w_valid_next = r_tvalid;
        if (w_start) begin
            w_data_next  = (r_mode == MODE_LFSR) ? w_lfsr_value : r_init;
            w_last_next  = (r_pkt_len == LEN_WIDTH'(1));
            w_cnt_next   = '0;
            w_valid_next = 1'b1;
        end else if (w_advance || w_carry) begin
            case (r_mode)
                MODE_CNT:    w_data_next = r_tdata + r_step;
                MODE_CONST:  w_data_next = r_init;
                MODE_LFSR:   w_data_next = w_lfsr_next;
                MODE_TOGGLE: w_data_next = ~r_tdata;
                default:     w_data_next = r_tdata;
            endcase
            if (w_advance) begin
                w_cnt_next  = r_beat_cnt + LEN_WIDTH'(1);
                w_last_next = w_framed && (w_cnt_next == (r_pkt_len - LEN_WIDTH'(1)));
            end else begin
                w_cnt_next  = '0;
                w_last_next = (cfg_pkt_len == LEN_WIDTH'(1));
            end
        end else if (w_restart) begin
            w_data_next = (mode_e'(cfg_mode) == MODE_LFSR) ? w_lfsr_next : cfg_init;
            w_cnt_next  = '0;
            w_last_next = (cfg_pkt_len == LEN_WIDTH'(1));
        end else if (w_stop) begin
            w_valid_next = 1'b0;
            w_last_next  = 1'b0;
        end else begin
            w_valid_next = r_tvalid;
        end
    end

    // State, shadow config, beat counter, output and status registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_CNT;
            r_init     <= '0;
            r_step     <= '0;
            r_pkt_len  <= '0;
            r_beat_cnt <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_pkt_cnt  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_beat_cnt <= w_cnt_next;
            r_tdata    <= w_data_next;
            r_tvalid   <= w_valid_next;
            r_tlast    <= w_last_next;
            r_busy     <= (w_state_next != ST_IDLE);
            if (w_latch_cfg) begin
                r_mode    <= mode_e'(cfg_mode);
                r_init    <= cfg_init;
                r_step    <= cfg_step;
                r_pkt_len <= cfg_pkt_len;
            end
            if (w_pkt_done) begin
                r_pkt_cnt <= r_pkt_cnt + STS_WIDTH'(1);
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign sts_pkt_cnt   = r_pkt_cnt;
    assign sts_busy      = r_busy;

endmodule
